// File: rtl/l1d_deq_serializer.sv
// Serializes up to IN_WIDTH parallel dequeue lanes into a single valid/ready stream.
// Lane 0 is issued first; valid and payload are driven directly from flops.
module l1d_deq_serializer #(
    parameter int unsigned PAYLOAD_WIDTH = 3,
    parameter int unsigned IN_WIDTH      = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [IN_WIDTH-1:0]               in_vld_i,
    input  logic [PAYLOAD_WIDTH*IN_WIDTH-1:0] in_payload_i,
    output logic [IN_WIDTH-1:0]               in_rdy_o,
    output logic                              out_vld_o,
    output logic [PAYLOAD_WIDTH-1:0]          out_payload_o,
    input  logic                              out_rdy_i,
    input  logic                              flush_i
);

    localparam int unsigned HEAD_W = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
    localparam int unsigned CNT_W  = $clog2(IN_WIDTH + 1);
    localparam int unsigned VLD_W  = IN_WIDTH + 1;

    logic [PAYLOAD_WIDTH-1:0] entry_q [IN_WIDTH];
    logic [HEAD_W-1:0]        head_q;
    logic [HEAD_W-1:0]        head_nxt;
    logic [CNT_W-1:0]         cnt_q;
    logic [CNT_W-1:0]         cnt_nxt;
    logic [CNT_W-1:0]         load_cnt;
    logic                     out_vld_q;
    logic                     out_vld_nxt;
    logic [PAYLOAD_WIDTH-1:0] out_payload_q;
    logic [PAYLOAD_WIDTH-1:0] out_payload_nxt;
    logic                     out_fire;
    logic                     can_load;
    logic                     load;
    logic [IN_WIDTH-1:0]      in_fire;
    logic [VLD_W-1:0]         vld_ext;
    logic                     vld_contig;

    // Accept a new group only when the buffer is empty or its last entry leaves this cycle.
    always_comb begin
        out_fire = out_vld_q & out_rdy_i;
        can_load = ~flush_i & ((cnt_q == '0) | ((cnt_q == CNT_W'(1)) & out_fire));
        in_fire  = in_vld_i & {IN_WIDTH{can_load}};
        load_cnt = '0;
        for (int unsigned i = 0; i < IN_WIDTH; i++) begin
            load_cnt = load_cnt + CNT_W'(in_fire[i]);
        end
        load = (load_cnt != '0);
    end

    // Ready is held low while reset is asserted.
    assign in_rdy_o = {IN_WIDTH{can_load & rst}};

    // Next-state: flush beats load, load beats drain.
    always_comb begin
        head_nxt        = head_q;
        cnt_nxt         = cnt_q;
        out_payload_nxt = out_payload_q;
        if (flush_i) begin
            head_nxt = '0;
            cnt_nxt  = '0;
        end else if (load) begin
            head_nxt = '0;
            cnt_nxt  = load_cnt;
        end else if (out_fire) begin
            head_nxt = head_q + HEAD_W'(1);
            cnt_nxt  = cnt_q - CNT_W'(1);
        end
        out_vld_nxt = (cnt_nxt != '0);
        if (load) begin
            out_payload_nxt = in_payload_i[PAYLOAD_WIDTH-1:0];
        end else begin
            for (int unsigned i = 0; i < IN_WIDTH; i++) begin
                if (HEAD_W'(i) == head_nxt) begin
                    out_payload_nxt = entry_q[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q    <= '0;
            cnt_q     <= '0;
            out_vld_q <= 1'b0;
        end else begin
            head_q    <= head_nxt;
            cnt_q     <= cnt_nxt;
            out_vld_q <= out_vld_nxt;
        end
    end

    // Data storage is not reset; contents are qualified by cnt.
    always_ff @(posedge clk) begin
        out_payload_q <= out_payload_nxt;
        for (int unsigned i = 0; i < IN_WIDTH; i++) begin
            if (in_fire[i]) begin
                entry_q[i] <= in_payload_i[i*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
            end
        end
    end

    assign out_vld_o     = out_vld_q;
    assign out_payload_o = out_payload_q;

    // Valid lanes must form a contiguous prefix starting at lane 0.
    always_comb begin
        vld_ext    = {1'b0, in_vld_i};
        vld_contig = ((vld_ext & (vld_ext + VLD_W'(1))) == '0);
    end

    a_vld_contig : assert property (@(posedge clk) disable iff (!rst) vld_contig)
        else $error("l1d_deq_serializer: non-contiguous in_vld_i %b", in_vld_i);

endmodule

// File: tb/tb_l1d_deq_serializer.sv
// Self-checking bench for l1d_deq_serializer: directed scenarios on a 4x3 instance and
// a random scoreboard sweep over several lane/payload widths.
module tb_l1d_deq_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [3:0]  in_vld;
    logic [11:0] in_pay;
    logic [3:0]  in_rdy;
    logic        out_vld;
    logic [2:0]  out_pay;
    logic        out_rdy;
    logic        flush;

    int n_checks = 0;
    int n_fail   = 0;
    logic [2:0] exp_q[$];
    logic [2:0] exp_v;
    bit sweep_go = 1'b0;

    l1d_deq_serializer #(.PAYLOAD_WIDTH(3), .IN_WIDTH(4)) u_dut (
        .clk(clk), .rst(rst), .in_vld_i(in_vld), .in_payload_i(in_pay), .in_rdy_o(in_rdy),
        .out_vld_o(out_vld), .out_payload_o(out_pay), .out_rdy_i(out_rdy), .flush_i(flush)
    );

    // Random sweep instances: (IN_WIDTH, PAYLOAD_WIDTH) = (1,64), (3,1), (4,64).
    for (genvar g = 0; g < 3; g++) begin : g_sweep
        localparam int unsigned SIW = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
        localparam int unsigned SPW = (g == 1) ? 1 : 64;
        logic [SIW-1:0]     s_vld;
        logic [SIW-1:0]     s_rdy;
        logic [SIW*SPW-1:0] s_pay;
        logic               s_ovld;
        logic               s_ordy;
        logic [SPW-1:0]     s_opay;
        logic [SPW-1:0]     sq[$];
        bit                 done = 1'b0;

        l1d_deq_serializer #(.PAYLOAD_WIDTH(SPW), .IN_WIDTH(SIW)) u_dut (
            .clk(clk), .rst(rst), .in_vld_i(s_vld), .in_payload_i(s_pay), .in_rdy_o(s_rdy),
            .out_vld_o(s_ovld), .out_payload_o(s_opay), .out_rdy_i(s_ordy), .flush_i(1'b0)
        );

        initial begin
            int          k;
            bit          exp_rdy;
            int unsigned sz;
            s_vld  = '0;
            s_pay  = '0;
            s_ordy = 1'b0;
            wait (sweep_go);
            @(negedge clk);
            for (int c = 0; c < 300; c++) begin
                sz = sq.size();
                n_checks++;
                if (s_ovld !== (sz != 0)) begin
                    n_fail++;
                    $display("FAIL sweep%0d_out_vld cycle %0d: got %b want %b", g, c, s_ovld, sz != 0);
                end
                if (sz != 0) begin
                    n_checks++;
                    if (s_opay !== sq[0]) begin
                        n_fail++;
                        $display("FAIL sweep%0d_payload cycle %0d: got %h want %h", g, c, s_opay, sq[0]);
                    end
                end
                s_ordy = ($urandom_range(3, 0) != 0);
                k = int'($urandom_range(SIW, 0));
                for (int j = 0; j < int'(SIW); j++) begin
                    s_vld[j] = (j < k);
                    s_pay[j*SPW +: SPW] = SPW'({$urandom(), $urandom()});
                end
                #1;
                exp_rdy = (sz == 0) || ((sz == 1) && s_ordy);
                n_checks++;
                if (s_rdy !== {SIW{exp_rdy}}) begin
                    n_fail++;
                    $display("FAIL sweep%0d_in_rdy cycle %0d: got %b want %b", g, c, s_rdy, {SIW{exp_rdy}});
                end
                if (s_ordy && (sz != 0)) void'(sq.pop_front());
                if (exp_rdy) begin
                    for (int j = 0; j < k; j++) sq.push_back(s_pay[j*SPW +: SPW]);
                end
                @(negedge clk);
            end
            s_vld  = '0;
            s_ordy = 1'b1;
            for (int d = 0; d < int'(SIW) + 2; d++) begin
                sz = sq.size();
                n_checks++;
                if (s_ovld !== (sz != 0)) begin
                    n_fail++;
                    $display("FAIL sweep%0d_drain_vld step %0d: got %b want %b", g, d, s_ovld, sz != 0);
                end
                if (sz != 0) begin
                    n_checks++;
                    if (s_opay !== sq[0]) begin
                        n_fail++;
                        $display("FAIL sweep%0d_drain_payload step %0d: got %h want %h", g, d, s_opay, sq[0]);
                    end
                    void'(sq.pop_front());
                end
                @(negedge clk);
            end
            done = 1'b1;
        end
    end

    task automatic test_reset();
        rst = 1'b0; in_vld = '0; in_pay = '0; out_rdy = 1'b0; flush = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (in_rdy !== 4'h0) begin n_fail++; $display("FAIL reset_in_rdy cycle %0d: got %h want 0", c, in_rdy); end
            n_checks++;
            if (out_vld !== 1'b0) begin n_fail++; $display("FAIL reset_out_vld cycle %0d: got %b want 0", c, out_vld); end
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (in_rdy !== 4'hF) begin n_fail++; $display("FAIL release_in_rdy: got %h want f", in_rdy); end
    endtask

    task automatic test_single_lane();
        in_vld = 4'b0001; in_pay = 12'h005; out_rdy = 1'b1;
        exp_q.push_back(3'h5);
        @(negedge clk);
        in_vld = '0;
        n_checks++;
        if (out_vld !== 1'b1) begin n_fail++; $display("FAIL single_vld: got %b want 1", out_vld); end
        exp_v = exp_q.pop_front();
        n_checks++;
        if (out_pay !== exp_v) begin n_fail++; $display("FAIL single_payload: got %h want %h", out_pay, exp_v); end
        @(negedge clk);
        n_checks++;
        if (out_vld !== 1'b0) begin n_fail++; $display("FAIL single_empty: got %b want 0", out_vld); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] want_rdy;
        in_vld = 4'hF; in_pay = {3'd7, 3'd6, 3'd5, 3'd4}; out_rdy = 1'b1;
        #1;
        n_checks++;
        if (in_rdy !== 4'hF) begin n_fail++; $display("FAIL b2b_first_rdy: got %h want f", in_rdy); end
        for (int j = 4; j < 8; j++) exp_q.push_back(3'(j));
        @(negedge clk);
        in_pay = {3'd3, 3'd2, 3'd1, 3'd0};
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (out_vld !== 1'b1) begin n_fail++; $display("FAIL b2b_vld cycle %0d: got %b want 1", i, out_vld); end
            exp_v = exp_q.pop_front();
            n_checks++;
            if (out_pay !== exp_v) begin n_fail++; $display("FAIL b2b_payload cycle %0d: got %h want %h", i, out_pay, exp_v); end
            want_rdy = (i == 3 || i == 7) ? 4'hF : 4'h0;
            n_checks++;
            if (in_rdy !== want_rdy) begin n_fail++; $display("FAIL b2b_in_rdy cycle %0d: got %h want %h", i, in_rdy, want_rdy); end
            if (i == 3) for (int j = 0; j < 4; j++) exp_q.push_back(3'(j));
            @(negedge clk);
            if (i == 3) in_vld = '0;
        end
        n_checks++;
        if (out_vld !== 1'b0) begin n_fail++; $display("FAIL b2b_empty: got %b want 0", out_vld); end
    endtask

    task automatic test_backpressure();
        in_vld = 4'b0111; in_pay = {3'd0, 3'd2, 3'd1, 3'd0}; out_rdy = 1'b1;
        for (int j = 0; j < 3; j++) exp_q.push_back(3'(j));
        @(negedge clk);
        in_vld = '0;
        exp_v = exp_q.pop_front();
        n_checks++;
        if (out_pay !== exp_v || out_vld !== 1'b1) begin n_fail++; $display("FAIL bp_first: got %b/%h want 1/%h", out_vld, out_pay, exp_v); end
        @(negedge clk);
        out_rdy = 1'b0; in_vld = 4'b0001; in_pay = 12'h007;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_checks++;
            if (out_vld !== 1'b1) begin n_fail++; $display("FAIL bp_stall_vld cycle %0d: got %b want 1", c, out_vld); end
            n_checks++;
            if (out_pay !== exp_q[0]) begin n_fail++; $display("FAIL bp_stall_payload cycle %0d: got %h want %h", c, out_pay, exp_q[0]); end
            n_checks++;
            if (in_rdy !== 4'h0) begin n_fail++; $display("FAIL bp_stall_in_rdy cycle %0d: got %h want 0", c, in_rdy); end
            @(negedge clk);
        end
        in_vld = '0; out_rdy = 1'b1;
        for (int c = 0; c < 2; c++) begin
            exp_v = exp_q.pop_front();
            n_checks++;
            if (out_vld !== 1'b1 || out_pay !== exp_v) begin n_fail++; $display("FAIL bp_resume step %0d: got %b/%h want 1/%h", c, out_vld, out_pay, exp_v); end
            @(negedge clk);
        end
        n_checks++;
        if (out_vld !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got %b want 0", out_vld); end
    endtask

    task automatic test_flush();
        in_vld = 4'hF; in_pay = {3'd4, 3'd3, 3'd2, 3'd1}; out_rdy = 1'b1;
        for (int j = 1; j < 5; j++) exp_q.push_back(3'(j));
        @(negedge clk);
        in_vld = '0;
        exp_v = exp_q.pop_front();
        n_checks++;
        if (out_vld !== 1'b1 || out_pay !== exp_v) begin n_fail++; $display("FAIL flush_drain1: got %b/%h want 1/%h", out_vld, out_pay, exp_v); end
        @(negedge clk);
        out_rdy = 1'b0; flush = 1'b1; in_vld = 4'b0011; in_pay = {3'd0, 3'd0, 3'd6, 3'd5};
        #1;
        n_checks++;
        if (out_vld !== 1'b1 || out_pay !== exp_q[0]) begin n_fail++; $display("FAIL flush_cycle_out: got %b/%h want 1/%h", out_vld, out_pay, exp_q[0]); end
        n_checks++;
        if (in_rdy !== 4'h0) begin n_fail++; $display("FAIL flush_cycle_in_rdy: got %h want 0", in_rdy); end
        exp_q.delete();
        @(negedge clk);
        flush = 1'b0;
        #1;
        n_checks++;
        if (out_vld !== 1'b0) begin n_fail++; $display("FAIL flush_after_vld: got %b want 0", out_vld); end
        n_checks++;
        if (in_rdy !== 4'hF) begin n_fail++; $display("FAIL flush_after_in_rdy: got %h want f", in_rdy); end
        exp_q.push_back(3'd5); exp_q.push_back(3'd6);
        @(negedge clk);
        in_vld = '0; out_rdy = 1'b1;
        for (int c = 0; c < 2; c++) begin
            exp_v = exp_q.pop_front();
            n_checks++;
            if (out_vld !== 1'b1 || out_pay !== exp_v) begin n_fail++; $display("FAIL flush_reload step %0d: got %b/%h want 1/%h", c, out_vld, out_pay, exp_v); end
            @(negedge clk);
        end
        n_checks++;
        if (out_vld !== 1'b0) begin n_fail++; $display("FAIL flush_empty: got %b want 0", out_vld); end
    endtask

    task automatic test_async_reset();
        in_vld = 4'hF; in_pay = {3'd7, 3'd3, 3'd5, 3'd1}; out_rdy = 1'b1;
        exp_q.push_back(3'd1); exp_q.push_back(3'd5); exp_q.push_back(3'd3); exp_q.push_back(3'd7);
        @(negedge clk);
        in_vld = '0;
        exp_v = exp_q.pop_front();
        n_checks++;
        if (out_vld !== 1'b1 || out_pay !== exp_v) begin n_fail++; $display("FAIL arst_pre: got %b/%h want 1/%h", out_vld, out_pay, exp_v); end
        @(negedge clk);
        out_rdy = 1'b0;
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if (out_vld !== 1'b0) begin n_fail++; $display("FAIL arst_out_vld: got %b want 0", out_vld); end
        n_checks++;
        if (in_rdy !== 4'h0) begin n_fail++; $display("FAIL arst_in_rdy: got %h want 0", in_rdy); end
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if (out_vld !== 1'b0 || in_rdy !== 4'hF) begin n_fail++; $display("FAIL arst_release: got %b/%h want 0/f", out_vld, in_rdy); end
        in_vld = 4'b0001; in_pay = 12'h003;
        exp_q.push_back(3'd3);
        @(negedge clk);
        in_vld = '0; out_rdy = 1'b1;
        exp_v = exp_q.pop_front();
        n_checks++;
        if (out_vld !== 1'b1 || out_pay !== exp_v) begin n_fail++; $display("FAIL arst_new: got %b/%h want 1/%h", out_vld, out_pay, exp_v); end
        @(negedge clk);
        n_checks++;
        if (out_vld !== 1'b0) begin n_fail++; $display("FAIL arst_empty: got %b want 0", out_vld); end
    endtask

    task automatic test_param_sweep();
        int c;
        sweep_go = 1'b1;
        c = 0;
        while (!(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done) && c < 1000) begin
            @(negedge clk);
            c++;
        end
        n_checks++;
        if (!(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done)) begin
            n_fail++;
            $display("FAIL sweep_timeout: got done=%b%b%b want 111", g_sweep[2].done, g_sweep[1].done, g_sweep[0].done);
        end
    endtask

    initial begin
        test_reset();
        test_single_lane();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_param_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
